// File: rtl/fifo_array_loader.sv
// fifo_array_loader: round-robin write sequencer feeding one tile into the systolic array's FIFO lanes
module fifo_array_loader #(
  parameter int data_size  = 8,
  parameter int array_size = 9,
  parameter int col_w      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [col_w-1:0]      cols,
  input  logic                  s_valid,
  input  logic [data_size-1:0]  s_data,
  output logic                  s_ready,
  input  logic [array_size-1:0] full,
  output logic [array_size-1:0] w_en,
  output logic [data_size-1:0]  in_bus,
  output logic                  clear,
  output logic                  busy,
  output logic                  done
);
  localparam int lw = $clog2(array_size);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, FLUSH, DONE} state_t;
  state_t state, nxt;
  logic [col_w-1:0] cols_q, col;
  logic [lw-1:0] lane;
  logic acc, last_lane, last_col;
  assign s_ready   = (state == LOAD) & ~full[lane];
  assign acc       = s_valid & s_ready;
  assign last_lane = lane == lw'(array_size - 1);
  assign last_col  = col == cols_q - col_w'(1);
  assign busy      = state != IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start ? CLEAR : IDLE;
      CLEAR: nxt = (cols_q == '0) ? DONE : LOAD;
      LOAD:  nxt = (acc & last_lane & last_col) ? FLUSH : LOAD;
      FLUSH: nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  // clear and done are registered decodes of the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cols_q <= '0;
      col    <= '0;
      lane   <= '0;
      w_en   <= '0;
      in_bus <= '0;
      clear  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= nxt;
      clear <= nxt == CLEAR;
      done  <= nxt == DONE;
      w_en  <= acc ? array_size'(1) << lane : '0;
      if (acc) in_bus <= s_data;
      if (state == IDLE && start) begin
        cols_q <= cols;
        col    <= '0;
        lane   <= '0;
      end else if (acc) begin
        lane <= last_lane ? '0 : lane + lw'(1);
        col  <= last_lane ? col + col_w'(1) : col;
      end
    end
  end
endmodule

// File: tb/tb_fifo_array_loader.sv
// tb_fifo_array_loader: table-driven tile scenarios plus a mid-tile reset sequence
module tb_fifo_array_loader;
  logic clk = 0, rst_n = 0, start = 0, s_valid = 0, s_ready, clear, busy, done;
  logic [7:0] cols = 0, s_data = 0, in_bus;
  logic [8:0] full = 0, w_en;
  int compared = 0, mismatched = 0;

  fifo_array_loader #(.data_size(8), .array_size(9), .col_w(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cols(cols), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .full(full), .w_en(w_en), .in_bus(in_bus),
    .clear(clear), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cols;
    int stall_lane;
    int stall_len;
    bit bubble;
    bit mid_start;
    int exp_done;
    int exp_writes;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_tile(input vec_t v);
    int k = 0, wr = 0, st = 0, done_cnt = 0, total;
    bit prev_acc = 0, acc;
    logic [7:0] mem [9][2];
    total = int'(v.cols) * 9;
    start = 1; cols = v.cols; s_valid = 0; full = 0;
    for (int cyc = 1; cyc <= v.exp_done + 2; cyc++) begin
      @(posedge clk); #1;
      if (prev_acc) k++;
      chk("clear", clear, cyc == 1);
      chk("write_after_accept", w_en != 0, prev_acc);
      if (w_en != 0) begin
        chk("w_en_lane", w_en, 9'(1) << (wr % 9));
        chk("in_bus", in_bus, wr + 1);
        if (wr / 9 < 2) mem[wr % 9][wr / 9] = in_bus;
        wr++;
      end
      if (done) begin
        done_cnt++;
        chk("done_cycle", cyc, v.exp_done);
      end
      if (cyc == v.exp_done + 1) chk("busy_end", busy, 0);
      start = v.mid_start && cyc == 8;
      cols = v.mid_start && cyc == 8 ? 8'd0 : v.cols;
      s_valid = k < total && !(v.bubble && cyc[0]);
      s_data = 8'(k + 1);
      full = 0;
      if (k == v.stall_lane && st < v.stall_len) begin
        full[v.stall_lane] = 1;
        st++;
      end
      #1;
      if (full != 0) chk("stall_ready", s_ready, 0);
      acc = s_valid && s_ready;
      prev_acc = acc;
    end
    chk("done_count", done_cnt, 1);
    chk("write_count", wr, v.exp_writes);
    if (v.cols == 2)
      for (int i = 0; i < 9; i++) begin
        chk("lane_col0", mem[i][0], i + 1);
        chk("lane_col1", mem[i][1], i + 10);
      end
    start = 0; s_valid = 0; full = 0;
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{8'd2, -1, 0, 0, 0, 21, 18};
    vecs[1] = '{8'd2,  3, 5, 0, 0, 26, 18};
    vecs[2] = '{8'd2, -1, 0, 1, 0, 38, 18};
    vecs[3] = '{8'd0, -1, 0, 0, 0,  2,  0};
    vecs[4] = '{8'd2, -1, 0, 0, 1, 21, 18};
    vecs[5] = '{8'd1, -1, 0, 0, 0, 12,  9};
    #12;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_w_en", w_en, 0);
    chk("rst_in_bus", in_bus, 0);
    chk("rst_clear", clear, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 6; i++) run_tile(vecs[i]);
    start = 1; cols = 2; s_valid = 0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(posedge clk); #1;
      start = 0;
      s_valid = cyc >= 2;
      s_data = 8'(cyc - 1);
    end
    chk("pre_rst_w_en", w_en, 9'h040);
    chk("pre_rst_in_bus", in_bus, 7);
    rst_n = 0; #1;
    chk("async_w_en", w_en, 0);
    chk("async_in_bus", in_bus, 0);
    chk("async_clear", clear, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_s_ready", s_ready, 0);
    s_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    run_tile(vecs[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fifo_array_loader.md
# fifo_array_loader

Write-side sequencer for the FIFO array that feeds the systolic array. It accepts a valid/ready element stream for one tile and distributes the elements round-robin across the array lanes, one element per lane per column. It drives the array's shared data bus, the one-hot per-lane write enables and the shared clear, and it respects per-lane full flags. It pulses `done` once the last element of the tile has been written.

## Interface
- `data_size`, 8, element width; equals the FIFO array's data width.
- `array_size`, 9, number of FIFO lanes; must be ≥ 2.
- `col_w`, 8, width of the tile column count.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to load one tile; sampled only in IDLE.
- `cols`  in  col_w  columns in the tile; sampled with `start`.
- `s_valid`  in  1  input element valid.
- `s_data`  in  data_size  input element.
- `s_ready`  out  1  loader accepts `s_data` this cycle.
- `full`  in  array_size  per-lane full flags from the FIFO array.
- `w_en`  out  array_size  one-hot per-lane write enable; registered.
- `in_bus`  out  data_size  shared FIFO write data; registered.
- `clear`  out  1  clear for all lanes; registered.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when the tile is complete.

## Operation
- States: IDLE, CLEAR, LOAD, FLUSH, DONE.
- IDLE -> CLEAR when `start`=1. Latch `cols`; reset lane pointer `lane` and column counter `col` to 0.
- CLEAR: `clear`=1 for exactly one cycle.
  - If the latched cols = 0, go to DONE.
  - Otherwise go to LOAD.
- LOAD:
  - `s_ready` = ~`full[lane]`. It is 0 in every other state.
  - Accept when `s_valid` & `s_ready`. On accept:
    - Register `w_en` = onehot(`lane`) and `in_bus` = `s_data` for the next cycle.
    - If `lane` = array_size-1, set `lane` to 0 and increment `col`. Otherwise increment `lane`.
  - Accepting element (`col`=cols-1, `lane`=array_size-1) moves the state to FLUSH.
- FLUSH: the last write is on `w_en`/`in_bus` this cycle; go to DONE.
- DONE: `done`=1 for one cycle; go to IDLE.
- Cycles without an accept: `w_en` = 0 and `in_bus` holds its last value.
- Element order on `s_data`: column-major. Element k goes to lane k mod array_size, column k div array_size.
- Full hazard:
  - Consecutive accepts target different lanes, because array_size ≥ 2.
  - The FIFO updates `full` at the edge that completes the write. A lane's flag is therefore current before that lane is targeted again.
  - No full prediction is required.
- A full lane stalls the whole stream. The loader never skips to another lane.
- `start` while `busy` is ignored. `cols` changes mid-tile have no effect.
- `full` changes while `s_ready`=0 cause no write.
- `rst_n` low at any time, including mid-tile:
  - State goes to IDLE.
  - `lane`, `col`, `w_en`, `in_bus`, `clear`, `done` and `busy` all go to 0.
  - A write that is in flight is dropped.
  - Partial FIFO contents are not the loader's concern; the next tile's CLEAR removes them.

## Timing
- Reset values: `s_ready`=0, `w_en`=0, `in_bus`=0, `clear`=0, `busy`=0, `done`=0.
- `start` sampled at edge 0:
  - `clear`=1 and `busy`=1 in cycle 1.
  - `s_ready` can first be 1 in cycle 2.
- Element accepted at edge t: its `w_en`/`in_bus` are valid in cycle t+1, and the FIFO writes at edge t+1.
- Throughput: one element per cycle when `s_valid`=1 and no lane is full.
- Last accept at edge t: FLUSH in cycle t+1, `done` in cycle t+2, IDLE and `busy`=0 in cycle t+3.
- Unstalled tile with array_size=9, cols=2 and `start` at edge 0:
  - 18 accepts at edges 2..19.
  - Writes in cycles 3..20.
  - `done` in cycle 21.
- cols=0: `clear` in cycle 1, `done` in cycle 2, no writes.

## Test plan
- Unstalled tile: array_size=9, cols=2, `s_data` = 1..18, `s_valid` held high.
  - `clear` pulses once in cycle 1.
  - `w_en` walks 0x001..0x100 twice in cycles 3..20.
  - `in_bus` = 1..18 in order.
  - `done` in cycle 21 only.
  - Each lane i ends holding {i+1, i+10}.
- Backpressure: hold `full[3]` high for 5 cycles when `lane`=3.
  - `s_ready`=0 for those 5 cycles and no `w_en` is asserted.
  - The stream resumes on lane 3 with no loss or duplication.
  - `done` is delayed by exactly 5 cycles.
- Bubbles: toggle `s_valid` 1,0,1,0…
  - Writes occur only one cycle after each accept.
  - `w_en`=0 in bubble cycles; the final contents match the unstalled case.
- cols=0 and `start` while busy:
  - cols=0 gives `clear` then `done`, with `w_en` never set.
  - A second `start` pulsed mid-tile is ignored: exactly one `done`, with no extra `clear`.
- Reset mid-operation: deassert `rst_n` after the 7th accept of a cols=2 tile.
  - All outputs go to 0 immediately (asynchronously).
  - After release, a new `start` produces `clear`, then a full correct tile starting at lane 0.
